// File: rtl/gf_horner_eval.sv
// rtl/gf_horner_eval.sv - Horner-rule polynomial evaluator over GF(2^3), poly x^3+x^2+1
//
// GFMult: combinational GF(2^3) multiplier, field polynomial x^3+x^2+1.
//   i_a, i_b : field elements
//   o_p      : i_a * i_b reduced modulo x^3+x^2+1
//
// gf_horner_eval: folds coefficients (highest degree first) as acc <- acc*x ^ c.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : request evaluation (sampled in IDLE only)
//   x_in, num_terms   : evaluation point and coefficient count, latched on start
//   coef_valid/ready  : coefficient handshake, coef_data carries the coefficient
//   result_valid      : one-cycle pulse, result holds p(x) until the next pulse
//   busy              : high in ACC and DONE
//   err               : one-cycle pulse on an illegal num_terms at start

module GFMult (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [2:0] o_p
);
    logic [4:0] w_prod;

    // Carry-less product, then fold the high terms back:
    // x^3 = x^2+1 (101), x^4 = x^3+x = x^2+x+1 (111).
    always_comb begin
        w_prod = 5'b0;
        for (int i = 0; i < 3; i++) begin
            if (i_b[i]) begin
                w_prod = w_prod ^ ({2'b00, i_a} << i);
            end
        end
        o_p = w_prod[2:0]
            ^ (w_prod[3] ? 3'b101 : 3'b000)
            ^ (w_prod[4] ? 3'b111 : 3'b000);
    end
endmodule

module gf_horner_eval #(
    parameter int N         = 3,
    parameter int MAX_TERMS = 8,
    parameter int CW        = $clog2(MAX_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  x_in,
    input  logic [CW-1:0] num_terms,
    input  logic          coef_valid,
    input  logic [N-1:0]  coef_data,
    output logic          coef_ready,
    output logic          result_valid,
    output logic [N-1:0]  result,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_n;
    logic [CW-1:0] r_cnt;
    logic          r_coef_ready;
    logic          r_result_valid;
    logic [N-1:0]  r_result;
    logic          r_busy;
    logic          r_err;

    logic [N-1:0]  w_mul;
    logic [N-1:0]  w_acc_next;
    logic [CW-1:0] w_cnt_inc;
    logic          w_count_ok;

    GFMult u_mult (
        .i_a (r_acc),
        .i_b (r_x),
        .o_p (w_mul)
    );

    assign w_acc_next = w_mul ^ coef_data;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_count_ok = (num_terms != '0) && (num_terms <= CW'(MAX_TERMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_x            <= '0;
            r_acc          <= '0;
            r_n            <= '0;
            r_cnt          <= '0;
            r_coef_ready   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_x          <= x_in;
                            r_n          <= num_terms;
                            r_acc        <= '0;
                            r_cnt        <= '0;
                            r_coef_ready <= 1'b1;
                            r_busy       <= 1'b1;
                            r_state      <= ACC;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    // coef_ready is always high in ACC, so coef_valid alone is a beat.
                    if (coef_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_n) begin
                            // Publish the final fold directly so result lines up
                            // with the DONE-cycle result_valid pulse.
                            r_result       <= w_acc_next;
                            r_result_valid <= 1'b1;
                            r_coef_ready   <= 1'b0;
                            r_state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_coef_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign coef_ready   = r_coef_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign busy         = r_busy;
    assign err          = r_err;
endmodule

// File: doc/gf_horner_eval.md
# gf_horner_eval

Sequential polynomial evaluator over GF(2^3) with field polynomial x^3+x^2+1 (α^3 = 101, α^7 = 001). It sits directly downstream of the combinational GF(2^3) multiplier `GFMult` and instantiates it as its only arithmetic element. Coefficients of p(z) = c[n-1]·z^(n-1) + … + c[0] stream in highest degree first over a valid/ready handshake. Horner's rule (acc ← acc·x ⊕ c) folds one coefficient per accepted beat and produces p(x).

## Interface
- N, 3, field element width; fixed to 3 because the `GFMult` reduction is hard-wired to x^3+x^2+1.
- MAX_TERMS, 8, maximum number of coefficients per evaluation.
- CW, $clog2(MAX_TERMS+1), width of the term count (4 at default).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new evaluation; sampled only in IDLE.
- x_in  in  N  evaluation point; latched on an accepted start.
- num_terms  in  CW  number of coefficients n; latched on start; legal range 1..MAX_TERMS.
- coef_valid  in  1  coef_data is valid.
- coef_data  in  N  next coefficient, highest degree first.
- coef_ready  out  1  block accepts a coefficient this cycle.
- result_valid  out  1  one-cycle pulse; result holds p(x).
- result  out  N  last evaluated value; held until the next result_valid.
- busy  out  1  high in ACC and DONE.
- err  out  1  one-cycle pulse on an illegal num_terms at start.

## Operation
- States: IDLE, ACC, DONE. Reset state is IDLE.
- IDLE:
  - start=1 with 1 ≤ num_terms ≤ MAX_TERMS: latch x_reg←x_in and n_reg←num_terms, clear acc←0 and cnt←0, go to ACC.
  - start=1 with num_terms=0 or num_terms>MAX_TERMS: err=1 next cycle, stay in IDLE, latch nothing.
- ACC: coef_ready=1. On a beat (coef_valid & coef_ready), acc ← GFMult(acc, x_reg) ⊕ coef_data and cnt ← cnt+1. When the beat brings cnt to n_reg, go to DONE. With no beat, state is held and there is no timeout.
- DONE: result ← acc, result_valid=1, then go to IDLE.
- The acc update uses the multiplier output combinationally in the same cycle, so there is exactly one GFMult instance.
- start is ignored in ACC and DONE. coef_valid is ignored outside ACC; no coefficient is consumed.
- Addition is bitwise XOR. No carries. All values are N bits.
- cnt is CW bits. It never wraps because n_reg ≤ MAX_TERMS.

## Timing
- Reset values: coef_ready=0, result_valid=0, result=000, busy=0, err=0. acc, cnt, x_reg and n_reg are 0. State is IDLE.
- Asserting rst mid-evaluation aborts immediately: all outputs go to reset values asynchronously and the partial result is discarded.
- Start accepted at edge t: coef_ready=1 from cycle t+1.
- Final beat at edge k: result_valid=1 and result valid in cycle k+1, busy=1 in cycle k+1, busy=0 and state IDLE in cycle k+2.
- Minimum latency start→result_valid is n+1 cycles with coef_valid held high. Each idle coef_valid cycle adds one cycle.
- coef_ready is a registered state decode with no combinational path from coef_valid. It drops in the cycle after the final beat.
- Earliest next start is sampled in cycle k+2 (IDLE).
- Illegal start at edge t: err=1 in cycle t+1 only. busy and coef_ready stay 0.
- A start coinciding with result_valid (DONE cycle) is dropped; it must be reasserted in IDLE.

## Test plan
- Linear: x_in=010, num_terms=2, coefs 001,001 back-to-back → after beat 1 acc=001, result=011. result_valid appears 3 cycles after start is accepted.
- Power: x_in=010, num_terms=3, coefs 010,000,000 → acc 010→100→101, result=101 (α^3).
- Field wrap: x_in=101, num_terms=2, coefs 111,000 → result=001 (α^4·α^3=α^7). Then a single term, num_terms=1 with coef 110 → result=110, result_valid 2 cycles after start.
- Throttling: repeat the linear case with coef_valid low for 3 cycles between the beats, and a start pulse during ACC → result=011 exactly 3 cycles later than the back-to-back case. The extra start is ignored; no second result_valid.
- Illegal count: num_terms=0, then num_terms=9 → err pulses one cycle each, no coef_ready, no result_valid, result unchanged.
- Reset abort: start x_in=010, num_terms=3, accept coef 011, assert rst for 1 cycle → all outputs 0 and coef_ready=0 during reset. A following power-case run still gives 101.
